// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: word buffer between a byte producer and uart_tx.
//
// Holds up to DEPTH words of WIDTH bits and presents the head word to the
// transmitter, so frames go out back-to-back. A word counts as taken one
// cycle after the transmitter drops its ready output, because uart_tx drops
// ready on the same edge at which it captures data.
//
// Optional feature: define UART_TX_FIFO_OVERFLOW_FLAG_EN to enable the
// sticky overflow flag. Without it, overflow is tied 0 and overflow_clear
// is ignored.
//
// Ports:
//   clock, resetn   system clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   producer side valid/ready handshake
//   tx_data   head word (0 when empty), to uart_tx data
//   tx_valid  buffer non-empty, to uart_tx can_send_next_word
//   tx_ready  from uart_tx ready; a 1->0 transition marks a capture
//   count     occupied entries (0..DEPTH)
//   full, empty   derived from count
//   overflow, overflow_clear   sticky refused-offer flag and its clear
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clear
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             tx_ready_q;
  logic             push;
  logic             pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign tx_valid = !empty;
  assign count    = count_q;

  // A push is refused while full even if a pop happens on the same edge,
  // so in_ready never depends on tx_ready.
  assign push = in_valid && !full;
  // Falling edge of ready, seen through last cycle's sample, means the
  // transmitter captured tx_data one cycle ago.
  assign pop  = tx_ready_q && !tx_ready && !empty;

  assign tx_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count and the
  // pointers, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      tx_ready_q <= tx_ready;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Set has priority over clear so a refused offer is never lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                overflow_q <= 1'b0;
    else if (in_valid && full)  overflow_q <= 1'b1;
    else if (overflow_clear)    overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;
`else
  logic unused_overflow_clear;

  assign unused_overflow_clear = overflow_clear;
  assign overflow              = 1'b0;
`endif

endmodule
